// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the 1-cycle-latency instruction SRAM and
// resolves branch/jump/jr redirects with one delay slot. Optional: FE_ADEL_CHECK_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stall,
    output logic        inst_sram_en,
    output logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_rdata,
    input  logic        de_is_b,
    input  logic        de_is_j,
    input  logic        de_is_jr,
    input  logic [3:0]  de_b_type,
    input  logic [15:0] de_b_offset,
    input  logic [25:0] de_j_index,
    input  logic [31:0] de_rs_data,
    input  logic [31:0] de_rt_data,
    output logic [31:0] fe_pc,
    output logic [31:0] fe_inst,
    output logic        fe_adel
);

    typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

    state_t      state, next_state;
    logic [31:0] pc, pend_tgt, hold_inst;
    logic        pend;

    logic [31:0] pc_seq, next_pc, tgt;
    logic        cond, take, advance;

    assign pc_seq  = pc + 32'd4;
    assign next_pc = pend ? pend_tgt : pc_seq;
    assign advance = (state != BOOT) && !stall;

    always_comb begin
        cond = 1'b0;
        case (de_b_type)
            4'd0:       cond = (de_rs_data != de_rt_data);
            4'd1:       cond = (de_rs_data == de_rt_data);
            4'd2, 4'd7: cond = !de_rs_data[31];
            4'd3:       cond = !de_rs_data[31] && (de_rs_data != 32'd0);
            4'd4:       cond = de_rs_data[31] || (de_rs_data == 32'd0);
            4'd5, 4'd6: cond = de_rs_data[31];
            default:    cond = 1'b0;
        endcase
    end

    assign take = de_is_j || de_is_jr || (de_is_b && cond);

    always_comb begin
        if (de_is_jr)
            tgt = de_rs_data;
        else if (de_is_j)
            tgt = {pc_seq[31:28], de_j_index, 2'b00};
        else
            tgt = pc_seq + {{14{de_b_offset[15]}}, de_b_offset, 2'b00};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= BOOT;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            BOOT:    next_state = RUN;
            RUN:     next_state = stall ? HOLD : RUN;
            HOLD:    next_state = stall ? HOLD : RUN;
            default: next_state = BOOT;
        endcase
    end

    // A taken redirect seen while a target is already pending sits in the delay slot and is dropped.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc        <= RESET_PC;
            pend      <= 1'b0;
            pend_tgt  <= 32'd0;
            hold_inst <= 32'd0;
        end else begin
            if (state == RUN && stall)
                hold_inst <= inst_sram_rdata;
            if (advance) begin
                pc <= next_pc;
                if (pend) begin
                    pend <= 1'b0;
                end else if (take) begin
                    pend     <= 1'b1;
                    pend_tgt <= tgt;
                end
            end
        end
    end

`ifdef FE_ADEL_CHECK_EN
    logic bad_pc;
    assign bad_pc = (state != BOOT) && (pc[1:0] != 2'b00);
`endif

    always_comb begin
        fe_pc          = pc;
        fe_inst        = 32'd0;
        fe_adel        = 1'b0;
        inst_sram_en   = 1'b0;
        inst_sram_addr = next_pc;
        case (state)
            BOOT: begin
                inst_sram_en   = 1'b1;
                inst_sram_addr = RESET_PC;
            end
            RUN: begin
                fe_inst      = inst_sram_rdata;
                inst_sram_en = !stall;
            end
            HOLD: begin
                fe_inst      = hold_inst;
                inst_sram_en = !stall;
            end
            default: ;
        endcase
`ifdef FE_ADEL_CHECK_EN
        if (bad_pc) begin
            fe_adel = 1'b1;
            fe_inst = 32'd0;
        end
        if (advance && next_pc[1:0] != 2'b00)
            inst_sram_en = 1'b0;
`endif
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage (default build): directed walk through redirect cases, then random
// decode/stall traffic against a PC-schedule reference model and a hashed SRAM image.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'hbfc00000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        stall;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata;
    logic        de_is_b, de_is_j, de_is_jr;
    logic [3:0]  de_b_type;
    logic [15:0] de_b_offset;
    logic [25:0] de_j_index;
    logic [31:0] de_rs_data, de_rt_data;
    logic [31:0] fe_pc, fe_inst;
    logic        fe_adel;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: boot flag, PC currently shown to decode, and the scheduled non-sequential fetches.
    logic        boot;
    logic [31:0] cur;
    logic [31:0] sched[$];

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .resetn(resetn), .stall(stall),
        .inst_sram_en(inst_sram_en), .inst_sram_addr(inst_sram_addr),
        .inst_sram_rdata(inst_sram_rdata),
        .de_is_b(de_is_b), .de_is_j(de_is_j), .de_is_jr(de_is_jr),
        .de_b_type(de_b_type), .de_b_offset(de_b_offset), .de_j_index(de_j_index),
        .de_rs_data(de_rs_data), .de_rt_data(de_rt_data),
        .fe_pc(fe_pc), .fe_inst(fe_inst), .fe_adel(fe_adel)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9e3779b1) ^ 32'h5a5ac3c3;
    endfunction

    // Synchronous SRAM; read data is garbage after a cycle without enable.
    always @(posedge clk)
        inst_sram_rdata <= inst_sram_en ? mem_word(inst_sram_addr) : $urandom;

    function automatic logic br_taken(input logic [3:0] t, input logic [31:0] rs, input logic [31:0] rt);
        case (t)
            4'd0:       return rs != rt;
            4'd1:       return rs == rt;
            4'd2, 4'd7: return $signed(rs) >= 0;
            4'd3:       return $signed(rs) > 0;
            4'd4:       return $signed(rs) <= 0;
            4'd5, 4'd6: return $signed(rs) < 0;
            default:    return 1'b0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_pc(input logic [31:0] lit);
        check("fe_pc_directed", fe_pc, lit);
    endtask

    // kind: 0 none, 1 branch, 2 j, 3 jr. Called at posedge+1; returns at the next posedge+1.
    task automatic cyc(input logic st, input logic [1:0] kind, input logic [3:0] bt,
                       input logic [15:0] off, input logic [25:0] idx,
                       input logic [31:0] rs, input logic [31:0] rt);
        logic [31:0] nxt, p4, target;
        logic        tk;
        stall = st;
        de_is_b = (kind == 2'd1);
        de_is_j = (kind == 2'd2);
        de_is_jr = (kind == 2'd3);
        de_b_type = bt;
        de_b_offset = off;
        de_j_index = idx;
        de_rs_data = rs;
        de_rt_data = rt;
        @(negedge clk);
        p4  = cur + 32'd4;
        nxt = (sched.size() != 0) ? sched[0] : p4;
        check("fe_pc", fe_pc, cur);
        check("fe_inst", fe_inst, boot ? 32'd0 : mem_word(cur));
        check("sram_en", {31'd0, inst_sram_en}, {31'd0, boot || !st});
        if (boot)
            check("sram_addr_boot", inst_sram_addr, RESET_PC);
        else if (!st)
            check("sram_addr", inst_sram_addr, nxt);
        check("fe_adel", {31'd0, fe_adel}, 32'd0);
        case (kind)
            2'd1:    begin tk = br_taken(bt, rs, rt); target = p4 + (32'($signed(off)) << 2); end
            2'd2:    begin tk = 1'b1; target = {p4[31:28], idx, 2'b00}; end
            2'd3:    begin tk = 1'b1; target = rs; end
            default: begin tk = 1'b0; target = 32'd0; end
        endcase
        if (boot) begin
            boot = 1'b0;
        end else if (!st) begin
            if (sched.size() != 0) begin
                cur = sched.pop_front();
            end else begin
                if (tk) sched.push_back(target);
                cur = p4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        st;
        logic [1:0]  kind;
        logic [3:0]  bt;
        logic [31:0] rs, rt, r;

        resetn = 1'b0;
        stall = 1'b0;
        de_is_b = 1'b0; de_is_j = 1'b0; de_is_jr = 1'b0;
        de_b_type = 4'd0; de_b_offset = 16'd0; de_j_index = 26'd0;
        de_rs_data = 32'd0; de_rt_data = 32'd0;
        boot = 1'b1;
        cur = RESET_PC;

        repeat (3) @(posedge clk);
        #1;
        check("rst_fe_pc", fe_pc, RESET_PC);
        check("rst_fe_inst", fe_inst, 32'd0);
        check("rst_fe_adel", {31'd0, fe_adel}, 32'd0);
        check("rst_sram_en", {31'd0, inst_sram_en}, 32'd1);
        check("rst_sram_addr", inst_sram_addr, RESET_PC);
        resetn = 1'b1;

        // Boot cycle ignores stall
        cyc(1'b1, 2'd0, 4'd0, 16'd0, 26'd0, 32'd0, 32'd0);
        expect_pc(32'hbfc00000);
        cyc(1'b0, 2'd0, 4'd0, 16'd0, 26'd0, 32'd0, 32'd0);
        expect_pc(32'hbfc00004);
        cyc(1'b0, 2'd0, 4'd0, 16'd0, 26'd0, 32'd0, 32'd0);
        repeat (3) begin
            expect_pc(32'hbfc00008);
            cyc(1'b1, 2'd0, 4'd0, 16'd0, 26'd0, 32'd0, 32'd0);
        end
        expect_pc(32'hbfc00008);
        cyc(1'b0, 2'd0, 4'd0, 16'd0, 26'd0, 32'd0, 32'd0);
        expect_pc(32'hbfc0000c);
        cyc(1'b0, 2'd0, 4'd0, 16'd0, 26'd0, 32'd0, 32'd0);
        // BEQ taken
        expect_pc(32'hbfc00010);
        cyc(1'b0, 2'd1, 4'd1, 16'h0003, 26'd0, 32'd5, 32'd5);
        expect_pc(32'hbfc00014);
        cyc(1'b0, 2'd0, 4'd0, 16'd0, 26'd0, 32'd0, 32'd0);
        expect_pc(32'hbfc00020);
        // J back to bfc00010
        cyc(1'b0, 2'd2, 4'd0, 16'd0, 26'h3f00004, 32'd0, 32'd0);
        expect_pc(32'hbfc00024);
        cyc(1'b0, 2'd0, 4'd0, 16'd0, 26'd0, 32'd0, 32'd0);
        expect_pc(32'hbfc00010);
        cyc(1'b0, 2'd1, 4'd5, 16'h0040, 26'd0, 32'd0, 32'd0);
        expect_pc(32'hbfc00014);
        cyc(1'b0, 2'd0, 4'd0, 16'd0, 26'd0, 32'd0, 32'd0);
        expect_pc(32'hbfc00018);
        cyc(1'b0, 2'd1, 4'd3, 16'h0040, 26'd0, 32'h80000000, 32'd0);
        expect_pc(32'hbfc0001c);
        cyc(1'b0, 2'd0, 4'd0, 16'd0, 26'd0, 32'd0, 32'd0);
        expect_pc(32'hbfc00020);
        repeat (4) cyc(1'b0, 2'd0, 4'd0, 16'd0, 26'd0, 32'd0, 32'd0);
        // JR held by two stall cycles
        expect_pc(32'hbfc00030);
        cyc(1'b1, 2'd3, 4'd0, 16'd0, 26'd0, 32'h80001000, 32'd0);
        expect_pc(32'hbfc00030);
        cyc(1'b1, 2'd3, 4'd0, 16'd0, 26'd0, 32'h80001000, 32'd0);
        expect_pc(32'hbfc00030);
        cyc(1'b0, 2'd3, 4'd0, 16'd0, 26'd0, 32'h80001000, 32'd0);
        expect_pc(32'hbfc00034);
        cyc(1'b0, 2'd0, 4'd0, 16'd0, 26'd0, 32'd0, 32'd0);
        expect_pc(32'h80001000);
        // Misaligned JR target passes through unchanged in this build
        cyc(1'b0, 2'd3, 4'd0, 16'd0, 26'd0, 32'h80001002, 32'd0);
        expect_pc(32'h80001004);
        cyc(1'b0, 2'd0, 4'd0, 16'd0, 26'd0, 32'd0, 32'd0);
        expect_pc(32'h80001002);
        cyc(1'b0, 2'd0, 4'd0, 16'd0, 26'd0, 32'd0, 32'd0);

        for (int i = 0; i < 400; i++) begin
            st   = ($urandom_range(0, 3) == 0);
            kind = 2'($urandom_range(0, 3));
            bt   = 4'($urandom_range(0, 15));
            r    = $urandom;
            case ($urandom_range(0, 3))
                0:       rs = 32'd0;
                1:       rs = r | 32'h80000000;
                default: rs = r & 32'hfffffffc;
            endcase
            rt = ($urandom_range(0, 1) == 0) ? rs : $urandom;
            cyc(st, kind, bt, 16'($urandom), 26'($urandom), rs, rt);
        end

        // Asynchronous reset mid-run, no clock edge
        resetn = 1'b0;
        #1;
        check("async_rst_fe_pc", fe_pc, RESET_PC);
        check("async_rst_fe_inst", fe_inst, 32'd0);
        check("async_rst_sram_addr", inst_sram_addr, RESET_PC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
